// File: rtl/uart_pkg.sv
// Shared constants for the UART-side blocks: state encodings, byte width and a
// constant-evaluable clog2 used to size index and counter fields.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WAIT_BUSY = 2'd1;
    localparam logic [1:0] ST_WAIT_DONE = 2'd2;

    // Never returns less than 1, so a 1-bit field is still legal for n <= 2.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set request bit after the last
// granted index, wrapping modulo N_REQ.
module uart_rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_last,
    output logic [IDX_W-1:0] o_winner,
    output logic             o_any
);

    logic w_found;
    int   w_idx;

    always_comb begin
        o_winner = i_last;
        w_found  = 1'b0;
        w_idx    = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_idx = (int'(i_last) + k) % N_REQ;
            if (!w_found && i_req[w_idx]) begin
                w_found  = 1'b1;
                o_winner = IDX_W'(w_idx);
            end
        end
        o_any = |i_req;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte sources;
// holds the grant until the transmitter reports idle again.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int DATA_W       = UART_DATA_W,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_en,
    input  logic [N_REQ-1:0]        i_req_valid,
    input  logic [N_REQ*DATA_W-1:0] i_req_data,
    output logic [N_REQ-1:0]        o_req_ack,
    output logic                    o_tx_start,
    output logic [DATA_W-1:0]       o_tx_data,
    input  logic                    i_tx_busy,
    output logic [clog2(N_REQ)-1:0] o_grant_id,
    output logic                    o_err_timeout
);

    localparam int IDX_W = clog2(N_REQ);
    localparam int CNT_W = clog2(BUSY_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [N_REQ-1:0]  r_ack;
    logic              r_start;
    logic [DATA_W-1:0] r_data;
    logic [IDX_W-1:0]  r_grant;
    logic              r_err;

    logic [IDX_W-1:0]  w_winner;
    logic              w_any;
    logic [DATA_W-1:0] w_sel_data;
    logic [N_REQ-1:0]  w_onehot;

    uart_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .i_req    (i_req_valid),
        .i_last   (r_grant),
        .o_winner (w_winner),
        .o_any    (w_any)
    );

    assign w_sel_data = i_req_data[int'(w_winner)*DATA_W +: DATA_W];
    assign w_onehot   = N_REQ'(1) << w_winner;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_ack   <= '0;
            r_start <= 1'b0;
            r_data  <= '0;
            r_grant <= IDX_W'(N_REQ - 1);
            r_err   <= 1'b0;
        end else begin
            r_ack   <= '0;
            r_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_en && !i_tx_busy && w_any) begin
                        r_data  <= w_sel_data;
                        r_grant <= w_winner;
                        r_ack   <= w_onehot;
                        r_start <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= ST_WAIT_BUSY;
                    end
                end
                ST_WAIT_BUSY: begin
                    if (i_tx_busy) begin
                        r_state <= ST_WAIT_DONE;
                    end else if (r_cnt == CNT_LAST) begin
                        // Transmitter never picked the byte up; it is dropped.
                        r_err   <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_WAIT_DONE: begin
                    if (!i_tx_busy) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_req_ack     = r_ack;
    assign o_tx_start    = r_start;
    assign o_tx_data     = r_data;
    assign o_grant_id    = r_grant;
    assign o_err_timeout = r_err;

endmodule
